// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: imem request/response, decode handshake and next-PC exchange.
// master = fetch unit, slave = memory / decode / next-PC environment.
interface instr_fetch_unit_if #(
    parameter int unsigned IMEM_AW = 32
);
    logic               imem_req;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic               imem_valid;
    logic [31:0]        instr;
    logic               instr_valid;
    logic               instr_ready;
    logic [31:0]        pc;
    logic [31:0]        pc_seq;
    logic [31:0]        npc;
    logic               npc_valid;
    logic               seq_err;
    logic               halted;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata, imem_valid,
        output instr, instr_valid,
        input  instr_ready,
        output pc, pc_seq,
        input  npc, npc_valid,
        output seq_err, halted
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata, imem_valid,
        input  instr, instr_valid,
        output instr_ready,
        input  pc, pc_seq,
        output npc, npc_valid,
        input  seq_err, halted
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Multicycle MIPS fetch stage: owns the PC, fetches one word per loop, hands it to decode.
// Optional halt-on-32'hFFFF_FFFF behaviour is enabled by defining FETCH_HALT_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IMEM_AW  = 32
) (
    input logic               clk,
    input logic               rst,
    instr_fetch_unit_if.master bus
);

`ifdef FETCH_HALT_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_WAIT_PC,
        S_HALTED
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_WAIT_PC
    } state_t;
`endif

    state_t      state;
    state_t      state_nxt;

    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        instr_valid_q;
    logic        imem_req_q;
    logic        seq_err_q;

    logic        capture;
    logic        accept;
    logic        load_pc;
    logic        err_set;
    logic        req_set;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        accept    = 1'b0;
        load_pc   = 1'b0;
        err_set   = 1'b0;
        case (state)
            S_IDLE: begin
                // imem_valid is deliberately not examined: drops a response left over from before reset
                state_nxt = S_FETCH;
                err_set   = bus.npc_valid;
            end
            S_FETCH: begin
                err_set = bus.npc_valid;
                // A response coincident with the request pulse is not a legal response
                if (bus.imem_valid && !imem_req_q) begin
`ifdef FETCH_HALT_EN
                    if (bus.imem_rdata == '1) begin
                        state_nxt = S_HALTED;
                    end else begin
                        capture   = 1'b1;
                        state_nxt = S_HOLD;
                    end
`else
                    capture   = 1'b1;
                    state_nxt = S_HOLD;
`endif
                end
            end
            S_HOLD: begin
                err_set = bus.npc_valid | bus.imem_valid;
                if (instr_valid_q && bus.instr_ready) begin
                    accept    = 1'b1;
                    state_nxt = S_WAIT_PC;
                end
            end
            S_WAIT_PC: begin
                err_set = bus.imem_valid;
                if (bus.npc_valid) begin
                    load_pc   = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
`ifdef FETCH_HALT_EN
            S_HALTED: begin
                err_set = bus.imem_valid;
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
        req_set = (state_nxt == S_FETCH) && (state != S_FETCH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
            seq_err_q     <= 1'b0;
        end else begin
            imem_req_q <= req_set;
            if (load_pc) pc_q <= bus.npc;
            if (capture) begin
                instr_q       <= bus.imem_rdata;
                instr_valid_q <= 1'b1;
            end else if (accept) begin
                instr_valid_q <= 1'b0;
            end
            if (err_set) seq_err_q <= 1'b1;
        end
    end

    assign bus.imem_req    = imem_req_q;
    assign bus.imem_addr   = pc_q[IMEM_AW-1:0];
    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.pc          = pc_q;
    assign bus.pc_seq      = pc_q + 32'd1;
    assign bus.seq_err     = seq_err_q;
`ifdef FETCH_HALT_EN
    assign bus.halted      = (state == S_HALTED);
`else
    assign bus.halted      = 1'b0;
`endif

endmodule
